des_link_ctrl: RTL and testbench
================================

# des_link_ctrl

Core-side command engine that sits directly downstream of the pin deserializer and directly upstream of the pin serializer. It consumes 24-bit frames assembled from the 6-bit inbound pins, decodes them into single-word bus reads and writes with auto-incrementing address, and queues read data as 32-bit words for the 8-bit outbound serializer. All logic runs on the fast pin clock. Frame and load strobes come from the serializer's phase counter.

## Interface
Parameters:
- FIFO_DEPTH, 4: response FIFO entries; power of two, range 2..16.

Ports:
- in_clk  input  1  clock, the pin-side fast clock.
- rst_n  input  1  reset, asynchronous, active-low.
- frame_valid  input  1  one-cycle pulse; frame_in holds a complete frame.
- frame_in  input  24  inbound frame. [23:20] = op, [19:16] = reserved, [15:0] = data.
- tx_load  input  1  one-cycle pulse; the serializer samples tx_word this cycle.
- tx_word  output  32  response FIFO head, or 32'h0 when the FIFO is empty.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  32  word address register.
- bus_wdata  output  32  write data register.
- bus_ack  input  1  completion; sampled only while bus_req = 1.
- bus_rdata  input  32  read data; valid in the bus_ack cycle.
- frame_drop  output  1  one-cycle pulse when a frame is discarded.
- err  output  1  sticky error flag; cleared only by reset.

## Operation
Opcodes:
- 0x0 NOP: no effect.
- 0x1 ADDR_LO: bus_addr[15:0] <= data.
- 0x2 ADDR_HI: bus_addr[31:16] <= data.
- 0x3 WDATA_LO: bus_wdata[15:0] <= data.
- 0x4 WRITE: bus_wdata[31:16] <= data, then a write cycle to bus_addr.
- 0x5 READ: a read cycle from bus_addr; bus_rdata is pushed to the FIFO.
- 0x6 to 0xF: ignored; err <= 1.

State machine:
- States are IDLE, WR, RD.
- IDLE dispatches a pending frame if one is held. Otherwise it dispatches the frame_valid frame.
- WRITE moves to WR. READ moves to RD only when FIFO count < FIFO_DEPTH; otherwise the READ stays pending and IDLE re-checks every cycle.
- WR and RD hold bus_req = 1 until bus_ack is sampled high, then return to IDLE.
- On the ack edge: bus_addr <= bus_addr + 4, modulo 2^32. RD also pushes bus_rdata.

Pending register:
- One entry. It captures frame_valid while the block is in WR or RD, or while a READ is blocked.
- If the entry is already full, the new frame is dropped: frame_drop pulses and err <= 1.

FIFO:
- Pop on tx_load when not empty. tx_load on an empty FIFO does nothing.
- Push and pop in the same cycle at full: both take effect and the count is unchanged.
- Push never overflows, because a READ issues only with space and at most one read is outstanding.

## Timing
- Reset values: tx_word = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, frame_drop = 0, err = 0. The FIFO is empty, the pending entry is empty, the state is IDLE.
- Reset asserted mid-operation clears everything asynchronously, including dropping bus_req.
- Register ops: the new value is visible the cycle after frame_valid.
- WRITE/READ in IDLE: bus_req and bus_we are valid the cycle after frame_valid, and bus_wdata[31:16] is updated on the same edge.
- bus_req deasserts the cycle after the bus_ack cycle. The minimum bus cycle is 1 req cycle when ack arrives in the first cycle.
- A pending frame dispatches in the first IDLE cycle.
- Read data is on tx_word the cycle after ack when the FIFO was empty.
- tx_word changes to the next entry the cycle after tx_load.
- bus_ack while bus_req = 0 is ignored.
- frame_valid arriving in the same cycle that ack returns the block to IDLE goes to the pending register.
- Nominal frame spacing is 8 cycles. The block must also accept back-to-back frame_valid pulses.

## Test plan
- Reset, then frames 0x1_0_1234, 0x2_0_ABCD -> bus_addr = 0xABCD1234, no bus_req, err = 0.
- With bus_addr = 0x100: frames 0x3_0_5678, then 0x4_0_9ABC, ack after 3 req cycles -> bus_we = 1, bus_wdata = 0x9ABC5678, bus_addr = 0x100 during req, then 0x104.
- Two READs with rdata 0x11111111 and 0x22222222 -> tx_word = 0x11111111; after tx_load it is 0x22222222; after a second tx_load it is 0.
- FIFO_DEPTH READs without tx_load, then one more READ -> no bus_req. Pulse tx_load -> the read issues the next cycle.
- Three frames while bus_ack is held low -> the first issues, the second is pending, the third pulses frame_drop and sets err. The pending frame executes after ack.
- Frame 0x7_0_0000 -> err = 1, no bus activity. Drop rst_n mid-WR -> bus_req falls immediately and all outputs read 0.

Source files
------------

// File: rtl/des_link_ctrl.sv
// des_link_ctrl: the command engine that sits between the pin deserializer and the pin serializer.
// It decodes 24-bit inbound frames into single-word bus reads and writes, and the address
// auto-increments after each access. Read data is queued for the outbound serializer.
//
// Ports:
//   in_clk, rst_n          pin clock; asynchronous active-low reset
//   frame_valid, frame_in  inbound frame strobe and payload ([23:20] op, [19:16] rsvd, [15:0] data)
//   tx_load, tx_word       serializer load strobe; response FIFO head (0 when empty)
//   bus_req/we/addr/wdata  bus request channel (all registered)
//   bus_ack, bus_rdata     bus completion and read data
//   frame_drop, err        discarded-frame pulse; sticky error flag
module des_link_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        in_clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [23:0] frame_in,
  input  logic        tx_load,
  output logic [31:0] tx_word,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        frame_drop,
  output logic        err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_ADDR_LO  = 4'h1;
  localparam logic [3:0] OP_ADDR_HI  = 4'h2;
  localparam logic [3:0] OP_WDATA_LO = 4'h3;
  localparam logic [3:0] OP_WRITE    = 4'h4;
  localparam logic [3:0] OP_READ     = 4'h5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic               r_req, w_req_nxt;
  logic               r_we, w_we_nxt;
  logic               r_pend_v, w_pend_v_nxt;
  logic [23:0]        r_pend_f, w_pend_f_nxt;
  logic               r_drop, w_drop_nxt;
  logic               r_err, w_err_nxt;
  logic [31:0]        r_tx, w_tx_nxt;
  logic [PTR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [31:0]        r_mem [FIFO_DEPTH];

  logic               w_src_v;
  logic [23:0]        w_src_f;
  logic               w_blocked;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_cnt_after_pop;

  // Reserved frame bits carry no meaning.
  logic w_unused_rsvd;
  assign w_unused_rsvd = ^{frame_in[19:16], r_pend_f[19:16]};

  // Next-state, frame dispatch, pending-slot and FIFO bookkeeping.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = r_we;
    w_pend_v_nxt = r_pend_v;
    w_pend_f_nxt = r_pend_f;
    w_err_nxt    = r_err;
    w_drop       = 1'b0;
    w_push       = 1'b0;
    w_src_v      = 1'b0;
    w_src_f      = frame_in;
    w_blocked    = 1'b0;
    w_pop        = tx_load && (r_count != '0);
    // A pop on this edge frees a slot in time for a READ dispatched on the same edge.
    w_cnt_after_pop = r_count - CNT_W'(w_pop);

    case (r_state)
      S_IDLE: begin
        // A held frame always goes before a newly arriving one.
        if (r_pend_v) begin
          w_src_v = 1'b1;
          w_src_f = r_pend_f;
        end else if (frame_valid) begin
          w_src_v = 1'b1;
          w_src_f = frame_in;
        end

        if (w_src_v) begin
          case (w_src_f[23:20])
            OP_NOP: begin
            end
            OP_ADDR_LO:  w_addr_nxt[15:0]  = w_src_f[15:0];
            OP_ADDR_HI:  w_addr_nxt[31:16] = w_src_f[15:0];
            OP_WDATA_LO: w_wdata_nxt[15:0] = w_src_f[15:0];
            OP_WRITE: begin
              w_wdata_nxt[31:16] = w_src_f[15:0];
              w_we_nxt           = 1'b1;
              w_state_nxt        = S_WR;
            end
            OP_READ: begin
              if (w_cnt_after_pop < CNT_W'(FIFO_DEPTH)) begin
                w_we_nxt    = 1'b0;
                w_state_nxt = S_RD;
              end else begin
                w_blocked = 1'b1;
              end
            end
            default: w_err_nxt = 1'b1;
          endcase
        end

        // Pending slot: keep a blocked READ, otherwise refill it from a frame that arrives alongside.
        if (r_pend_v) begin
          if (w_blocked) begin
            w_drop = frame_valid;
          end else begin
            w_pend_v_nxt = frame_valid;
            w_pend_f_nxt = frame_in;
          end
        end else if (w_blocked) begin
          w_pend_v_nxt = 1'b1;
          w_pend_f_nxt = frame_in;
        end
      end

      S_WR, S_RD: begin
        if (frame_valid) begin
          if (r_pend_v) begin
            w_drop = 1'b1;
          end else begin
            w_pend_v_nxt = 1'b1;
            w_pend_f_nxt = frame_in;
          end
        end
        if (bus_ack) begin
          w_addr_nxt  = r_addr + 32'd4;
          w_push      = (r_state == S_RD);
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_drop_nxt = w_drop;
    if (w_drop) begin
      w_err_nxt = 1'b1;
    end
    w_req_nxt = (w_state_nxt != S_IDLE);

    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    w_count_nxt  = w_cnt_after_pop + CNT_W'(w_push);

    // Registered FIFO head: the pushed word becomes the head only when nothing else remains.
    if (w_count_nxt == '0) begin
      w_tx_nxt = 32'h0;
    end else if (w_push && (w_cnt_after_pop == '0)) begin
      w_tx_nxt = bus_rdata;
    end else begin
      w_tx_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // State and control registers.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend_f <= 24'h0;
      r_drop   <= 1'b0;
      r_err    <= 1'b0;
      r_tx     <= 32'h0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_req    <= w_req_nxt;
      r_we     <= w_we_nxt;
      r_pend_v <= w_pend_v_nxt;
      r_pend_f <= w_pend_f_nxt;
      r_drop   <= w_drop_nxt;
      r_err    <= w_err_nxt;
      r_tx     <= w_tx_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // FIFO storage. It needs no reset because tx_word is gated by the count.
  always_ff @(posedge in_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus_rdata;
    end
  end

  assign tx_word    = r_tx;
  assign bus_req    = r_req;
  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_wdata  = r_wdata;
  assign frame_drop = r_drop;
  assign err        = r_err;

endmodule

// File: tb/tb_des_link_ctrl.sv
// Directed bench for des_link_ctrl. It uses a cycle table for the basic register, write and read
// behaviour, plus hand-written sequences for FIFO-full blocking, the pending slot and drops, and
// asynchronous reset in the middle of an access.
module tb_des_link_ctrl;

  logic        in_clk;
  logic        rst_n;
  logic        frame_valid;
  logic [23:0] frame_in;
  logic        tx_load;
  logic [31:0] tx_word;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        frame_drop;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  des_link_ctrl #(.FIFO_DEPTH(4)) dut (
    .in_clk     (in_clk),
    .rst_n      (rst_n),
    .frame_valid(frame_valid),
    .frame_in   (frame_in),
    .tx_load    (tx_load),
    .tx_word    (tx_word),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .frame_drop (frame_drop),
    .err        (err)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  typedef struct {
    logic        fv;
    logic [23:0] fr;
    logic        ack;
    logic        ld;
    logic [31:0] rd;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] tx;
    logic        err;
    logic        drop;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic fv, input logic [23:0] fr, input logic ack,
                      input logic ld, input logic [31:0] rd);
    frame_valid = fv;
    frame_in    = fr;
    bus_ack     = ack;
    tx_load     = ld;
    bus_rdata   = rd;
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 24'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    frame_in    = 24'h0;
    bus_ack     = 1'b0;
    tx_load     = 1'b0;
    bus_rdata   = 32'h0;
    rst_n       = 1'b0;
    #2;
    rst_n       = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tx_word"},    tx_word,    32'h0);
    chk({tag, " bus_req"},    32'(bus_req), 32'h0);
    chk({tag, " bus_we"},     32'(bus_we),  32'h0);
    chk({tag, " bus_addr"},   bus_addr,   32'h0);
    chk({tag, " bus_wdata"},  bus_wdata,  32'h0);
    chk({tag, " frame_drop"}, 32'(frame_drop), 32'h0);
    chk({tag, " err"},        32'(err),   32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_in    = 24'h0;
    bus_ack     = 1'b0;
    tx_load     = 1'b0;
    bus_rdata   = 32'h0;

    //            fv    frame      ack   ld    rdata          req   we    addr           wdata          tx             err   drop
    vecs[0]  = '{1'b1, 24'h101234, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h00001234, 32'h00000000, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 24'h20ABCD, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hABCD1234, 32'h00000000, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b1, 24'h000000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hABCD1234, 32'h00000000, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 24'h100100, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hABCD0100, 32'h00000000, 32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b1, 24'h200000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h00000100, 32'h00000000, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b1, 24'h305678, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h00000100, 32'h00005678, 32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b1, 24'h409ABC, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00000100, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[7]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00000100, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00000100, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[9]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h00000104, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h00000104, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[11] = '{1'b1, 24'h500000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00000104, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[12] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'h11111111,  1'b0, 1'b0, 32'h00000108, 32'h9ABC5678, 32'h11111111,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 24'h500000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00000108, 32'h9ABC5678, 32'h11111111,  1'b0, 1'b0};
    vecs[14] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'h22222222,  1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h11111111,  1'b0, 1'b0};
    vecs[15] = '{1'b0, 24'h000000, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h22222222,  1'b0, 1'b0};
    vecs[16] = '{1'b0, 24'h000000, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[17] = '{1'b0, 24'h000000, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h0,         1'b0, 1'b0};
    vecs[18] = '{1'b1, 24'h700000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h0,         1'b1, 1'b0};
    vecs[19] = '{1'b0, 24'h000000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000010C, 32'h9ABC5678, 32'h0,         1'b1, 1'b0};

    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Table: register ops, a write with a 3-cycle request, two reads, pops, and an illegal opcode.
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].fv, vecs[i].fr, vecs[i].ack, vecs[i].ld, vecs[i].rd);
      chk($sformatf("v%0d bus_req", i),    32'(bus_req),    32'(vecs[i].req));
      chk($sformatf("v%0d bus_we", i),     32'(bus_we),     32'(vecs[i].we));
      chk($sformatf("v%0d bus_addr", i),   bus_addr,        vecs[i].addr);
      chk($sformatf("v%0d bus_wdata", i),  bus_wdata,       vecs[i].wdata);
      chk($sformatf("v%0d tx_word", i),    tx_word,         vecs[i].tx);
      chk($sformatf("v%0d err", i),        32'(err),        32'(vecs[i].err));
      chk($sformatf("v%0d frame_drop", i), 32'(frame_drop), 32'(vecs[i].drop));
    end

    // FIFO full: four reads fill it, and a fifth READ waits until a pop frees a slot.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 24'h500000, 1'b0, 1'b0, 32'h0);
      chk($sformatf("fill%0d req", i), 32'(bus_req), 32'h1);
      step(1'b0, 24'h0, 1'b1, 1'b0, 32'hA0000000 + 32'(i));
    end
    chk("full head", tx_word, 32'hA0000000);
    step(1'b1, 24'h500000, 1'b0, 1'b0, 32'h0);
    chk("blocked req", 32'(bus_req), 32'h0);
    idle();
    idle();
    chk("still blocked req", 32'(bus_req), 32'h0);
    chk("blocked addr", bus_addr, 32'h10);
    step(1'b0, 24'h0, 1'b0, 1'b1, 32'h0);
    chk("unblocked req", 32'(bus_req), 32'h1);
    chk("unblocked we", 32'(bus_we), 32'h0);
    chk("after pop head", tx_word, 32'hA0000001);
    step(1'b0, 24'h0, 1'b1, 1'b0, 32'hB0000005);
    chk("fifth ack req", 32'(bus_req), 32'h0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_w;
      exp_w = (i < 3) ? (32'hA0000001 + 32'(i)) : ((i == 3) ? 32'hB0000005 : 32'h0);
      chk($sformatf("drain%0d tx_word", i), tx_word, exp_w);
      step(1'b0, 24'h0, 1'b0, 1'b1, 32'h0);
    end
    chk("drained tx_word", tx_word, 32'h0);
    chk("fifo err", 32'(err), 32'h0);

    // Back-to-back frames while the bus stalls: the first issues, the second is held, the third drops.
    do_reset();
    step(1'b1, 24'h400001, 1'b0, 1'b0, 32'h0);
    chk("b2b wr req", 32'(bus_req), 32'h1);
    chk("b2b wr we", 32'(bus_we), 32'h1);
    chk("b2b wdata", bus_wdata, 32'h00010000);
    step(1'b1, 24'h500000, 1'b0, 1'b0, 32'h0);
    chk("b2b pend drop", 32'(frame_drop), 32'h0);
    chk("b2b pend err", 32'(err), 32'h0);
    step(1'b1, 24'h300002, 1'b0, 1'b0, 32'h0);
    chk("b2b drop pulse", 32'(frame_drop), 32'h1);
    chk("b2b drop err", 32'(err), 32'h1);
    chk("b2b dropped wdata", bus_wdata, 32'h00010000);
    idle();
    chk("b2b drop one cycle", 32'(frame_drop), 32'h0);
    chk("b2b still req", 32'(bus_req), 32'h1);
    step(1'b0, 24'h0, 1'b1, 1'b0, 32'h0);
    chk("b2b ack req", 32'(bus_req), 32'h0);
    chk("b2b ack addr", bus_addr, 32'h4);
    idle();
    chk("b2b pend rd req", 32'(bus_req), 32'h1);
    chk("b2b pend rd we", 32'(bus_we), 32'h0);
    step(1'b0, 24'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    chk("b2b rd tx_word", tx_word, 32'hCAFEF00D);
    chk("b2b rd addr", bus_addr, 32'h8);
    chk("b2b err sticky", 32'(err), 32'h1);

    // Asynchronous reset in the middle of a write.
    do_reset();
    step(1'b1, 24'h40FFFF, 1'b0, 1'b0, 32'h0);
    chk("pre-rst req", 32'(bus_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    #1;
    rst_n = 1'b1;
    idle();
    chk("post-rst req", 32'(bus_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
